// File: rtl/bm_mem_ctrl.sv
// Bit-matrix row memory: host writes a row as BEATS beats and commits it in one cycle.
// The controller reads rows with one-cycle latency, range-checked against the live MReg.
module bm_mem_ctrl #(
  parameter  int unsigned K_MAX         = 128,
  parameter  int unsigned M_MAX         = 128,
  parameter  int unsigned W             = 4,
  parameter  int unsigned HOST_DATA_W   = 32,
  localparam int unsigned BM_COL_W      = W * W * K_MAX,
  localparam int unsigned BM_MEM_ADDR_W = $clog2(M_MAX),
  localparam int unsigned BEATS         = BM_COL_W / HOST_DATA_W,
  // MReg must be able to hold M_MAX itself (every row valid)
  localparam int unsigned MREG_W        = $clog2(M_MAX + 1)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [MREG_W-1:0]        MReg,
  input  logic                     host_wr_valid,
  output logic                     host_wr_ready,
  input  logic [BM_MEM_ADDR_W-1:0] host_wr_row,
  input  logic [HOST_DATA_W-1:0]   host_wr_data,
  input  logic                     bm_cntl_bm_mem_rd_rq,
  input  logic [BM_MEM_ADDR_W-1:0] bm_cntl_bm_mem_rd_addr,
  output logic [BM_COL_W-1:0]      bm_mem_bm_cntl_rd_data,
  output logic                     bm_mem_bm_cntl_rd_data_val,
  output logic                     bm_mem_load_done,
  input  logic                     bm_mem_err_clr,
  output logic                     bm_mem_err
);

  localparam int unsigned BEAT_W = $clog2(BEATS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [BEAT_W-1:0]        beat_q, beat_d;
  logic [BM_MEM_ADDR_W-1:0] row_q, row_d;
  logic [BM_COL_W-1:0]      buf_q, buf_d;
  logic                     ready_q, ready_d;
  logic                     err_q, err_d;
  logic                     rd_val_q;
  logic [BM_COL_W-1:0]      rd_data_q, rd_data_d;

  logic [BM_COL_W-1:0]      mem_q [M_MAX];

  logic wr_accept;
  logic commit_in_range;
  logic is_commit;
  logic mem_we;
  logic rd_in_range;
  logic err_set;

  assign wr_accept       = host_wr_valid && ready_q;
  assign is_commit       = (state_q == ST_COMMIT);
  assign commit_in_range = (MREG_W'(row_q) < MReg);
  assign mem_we          = is_commit && commit_in_range;
  assign rd_in_range     = (MREG_W'(bm_cntl_bm_mem_rd_addr) < MReg);
  assign err_set         = (is_commit && !commit_in_range) ||
                           (bm_cntl_bm_mem_rd_rq && !rd_in_range);

  // Write FSM: gather beats into the row buffer, then commit for one cycle
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    row_d   = row_q;
    buf_d   = buf_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_accept) begin
          row_d = host_wr_row;
          buf_d[beat_q*HOST_DATA_W +: HOST_DATA_W] = host_wr_data;
          beat_d  = beat_q + BEAT_W'(1);
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (wr_accept) begin
          buf_d[beat_q*HOST_DATA_W +: HOST_DATA_W] = host_wr_data;
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            beat_d  = '0;
            state_d = ST_COMMIT;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    ready_d = (state_d != ST_COMMIT);
  end

  // Sticky error: a same-cycle set beats the clear
  always_comb begin
    err_d = err_q;
    if (bm_mem_err_clr) err_d = 1'b0;
    if (err_set)        err_d = 1'b1;
  end

  // Read path: out-of-range rows read as zero; idle cycles hold the last data
  always_comb begin
    rd_data_d = rd_data_q;
    if (bm_cntl_bm_mem_rd_rq) begin
      rd_data_d = rd_in_range ? mem_q[bm_cntl_bm_mem_rd_addr] : '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      beat_q    <= '0;
      row_q     <= '0;
      buf_q     <= '0;
      ready_q   <= 1'b1;
      err_q     <= 1'b0;
      rd_val_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      row_q     <= row_d;
      buf_q     <= buf_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      rd_val_q  <= bm_cntl_bm_mem_rd_rq;
      rd_data_q <= rd_data_d;
    end
  end

  // Row storage, not reset; a read of the committing row sees the old contents
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[row_q] <= buf_q;
  end

  assign host_wr_ready              = ready_q;
  assign bm_mem_bm_cntl_rd_data     = rd_data_q;
  assign bm_mem_bm_cntl_rd_data_val = rd_val_q;
  assign bm_mem_err                 = err_q;
  assign bm_mem_load_done           = mem_we && ((MREG_W'(row_q) + MREG_W'(1)) == MReg);

endmodule

// File: tb/tb_bm_mem_ctrl.sv
// Directed bench for bm_mem_ctrl with K_MAX=4, M_MAX=4, W=4, HOST_DATA_W=16 (4 beats, 64-bit rows).
module tb_bm_mem_ctrl;

  localparam int unsigned HDW = 16;
  localparam int unsigned COL = 64;
  localparam int unsigned AW  = 2;
  localparam int unsigned MW  = 3;

  localparam logic [63:0] D_V1 = 64'h4444_3333_2222_1111;
  localparam logic [63:0] D_V2 = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] D_V3 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D_V4 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] D_V5 = 64'hDEAD_BEEF_DEAD_BEEF;
  localparam logic [63:0] D_A  = 64'h5555_6666_7777_8888;
  localparam logic [63:0] D_B  = 64'h0BB0_1BB1_2BB2_3BB3;
  localparam logic [63:0] D_C  = 64'hC0C0_C1C1_C2C2_C3C3;

  logic            clk;
  logic            rstn;
  logic [MW-1:0]   MReg;
  logic            host_wr_valid;
  logic            host_wr_ready;
  logic [AW-1:0]   host_wr_row;
  logic [HDW-1:0]  host_wr_data;
  logic            rd_rq;
  logic [AW-1:0]   rd_addr;
  logic [COL-1:0]  rd_data;
  logic            rd_val;
  logic            load_done;
  logic            err_clr;
  logic            err;

  int n_tests = 0;
  int n_fail  = 0;

  bm_mem_ctrl #(
    .K_MAX(4), .M_MAX(4), .W(4), .HOST_DATA_W(HDW)
  ) dut (
    .clk                        (clk),
    .rstn                       (rstn),
    .MReg                       (MReg),
    .host_wr_valid              (host_wr_valid),
    .host_wr_ready              (host_wr_ready),
    .host_wr_row                (host_wr_row),
    .host_wr_data               (host_wr_data),
    .bm_cntl_bm_mem_rd_rq       (rd_rq),
    .bm_cntl_bm_mem_rd_addr     (rd_addr),
    .bm_mem_bm_cntl_rd_data     (rd_data),
    .bm_mem_bm_cntl_rd_data_val (rd_val),
    .bm_mem_load_done           (load_done),
    .bm_mem_err_clr             (err_clr),
    .bm_mem_err                 (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [MW-1:0] mreg;
    logic [AW-1:0] wrow;
    logic [63:0]   wdata;
    logic          exp_done;
    logic [AW-1:0] rrow;
    logic [63:0]   exp_rdata;
    logic          exp_err;
  } vec_t;

  vec_t vecs [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Four beats; later beats carry a bogus row that must be ignored
  task automatic do_write(input logic [AW-1:0] row, input logic [63:0] data,
                          input logic exp_done, input string tag);
    for (int i = 0; i < 4; i++) begin
      host_wr_valid = 1'b1;
      host_wr_row   = (i == 0) ? row : ~row;
      host_wr_data  = data[i*HDW +: HDW];
      chk($sformatf("%s_ready_beat%0d", tag, i), host_wr_ready, 1'b1);
      step();
    end
    host_wr_valid = 1'b0;
    chk($sformatf("%s_ready_commit", tag), host_wr_ready, 1'b0);
    chk($sformatf("%s_done_commit", tag), load_done, exp_done);
    step();
    chk($sformatf("%s_ready_after", tag), host_wr_ready, 1'b1);
    chk($sformatf("%s_done_after", tag), load_done, 1'b0);
  endtask

  task automatic do_read(input logic [AW-1:0] row, input logic [63:0] exp, input string tag);
    rd_rq   = 1'b1;
    rd_addr = row;
    step();
    chk($sformatf("%s_rd_val", tag), rd_val, 1'b1);
    chk($sformatf("%s_rd_data", tag), rd_data, exp);
    rd_rq = 1'b0;
    step();
    chk($sformatf("%s_rd_val_idle", tag), rd_val, 1'b0);
    chk($sformatf("%s_rd_data_hold", tag), rd_data, exp);
  endtask

  initial begin
    logic [63:0] exp_rows [4];

    vecs[0] = '{3'd4, 2'd2, D_V1, 1'b0, 2'd2, D_V1, 1'b0};
    vecs[1] = '{3'd3, 2'd2, D_V2, 1'b1, 2'd2, D_V2, 1'b0};
    vecs[2] = '{3'd4, 2'd0, D_V3, 1'b0, 2'd0, D_V3, 1'b0};
    vecs[3] = '{3'd4, 2'd3, D_V4, 1'b1, 2'd3, D_V4, 1'b0};
    vecs[4] = '{3'd2, 2'd3, D_V5, 1'b0, 2'd0, D_V3, 1'b1};
    vecs[5] = '{3'd4, 2'd1, D_A,  1'b0, 2'd3, D_V4, 1'b0};

    rstn          = 1'b0;
    MReg          = 3'd4;
    host_wr_valid = 1'b0;
    host_wr_row   = '0;
    host_wr_data  = '0;
    rd_rq         = 1'b0;
    rd_addr       = '0;
    err_clr       = 1'b0;

    #12;
    chk("rst_val", rd_val, 1'b0);
    chk("rst_done", load_done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_data", rd_data, 64'h0);
    step();
    rstn = 1'b1;
    step();
    chk("rst_ready", host_wr_ready, 1'b1);

    for (int i = 0; i < 6; i++) begin
      MReg = vecs[i].mreg;
      do_write(vecs[i].wrow, vecs[i].wdata, vecs[i].exp_done, $sformatf("v%0d", i));
      do_read(vecs[i].rrow, vecs[i].exp_rdata, $sformatf("v%0d", i));
      chk($sformatf("v%0d_err", i), err, vecs[i].exp_err);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk($sformatf("v%0d_err_clr", i), err, 1'b0);
    end

    // Out-of-range read, sticky error, set beats clear
    MReg = 3'd2;
    do_read(2'd3, 64'h0, "oor");
    chk("oor_err", err, 1'b1);
    step();
    step();
    chk("oor_err_sticky", err, 1'b1);
    err_clr = 1'b1;
    rd_rq   = 1'b1;
    rd_addr = 2'd3;
    step();
    err_clr = 1'b0;
    rd_rq   = 1'b0;
    chk("oor_set_wins", err, 1'b1);
    chk("oor_set_wins_val", rd_val, 1'b1);
    chk("oor_set_wins_data", rd_data, 64'h0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("oor_clr", err, 1'b0);

    // Read of row 1 in its own COMMIT cycle sees the old row
    MReg = 3'd4;
    for (int i = 0; i < 4; i++) begin
      host_wr_valid = 1'b1;
      host_wr_row   = 2'd1;
      host_wr_data  = D_B[i*HDW +: HDW];
      step();
    end
    host_wr_valid = 1'b0;
    chk("raw_ready_commit", host_wr_ready, 1'b0);
    rd_rq   = 1'b1;
    rd_addr = 2'd1;
    step();
    chk("raw_old_val", rd_val, 1'b1);
    chk("raw_old_data", rd_data, D_A);
    step();
    chk("raw_new_data", rd_data, D_B);
    rd_rq = 1'b0;
    step();

    // Reset mid-fill with a read pending and the error flag set
    MReg    = 3'd2;
    rd_rq   = 1'b1;
    rd_addr = 2'd3;
    step();
    rd_rq = 1'b0;
    chk("mid_rst_pre_err", err, 1'b1);
    MReg          = 3'd4;
    host_wr_valid = 1'b1;
    host_wr_row   = 2'd0;
    host_wr_data  = 16'hBAD0;
    step();
    host_wr_data = 16'hBAD1;
    rd_rq        = 1'b1;
    rd_addr      = 2'd0;
    step();
    chk("mid_rst_pre_data", rd_data, D_V3);
    host_wr_valid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_val", rd_val, 1'b0);
    chk("mid_rst_data", rd_data, 64'h0);
    chk("mid_rst_err", err, 1'b0);
    chk("mid_rst_done", load_done, 1'b0);
    step();
    chk("mid_rst_val_edge", rd_val, 1'b0);
    rd_rq = 1'b0;
    rstn  = 1'b1;
    step();
    chk("mid_rst_ready", host_wr_ready, 1'b1);
    do_write(2'd0, D_C, 1'b0, "post_rst");
    do_read(2'd0, D_C, "post_rst");

    // Back-to-back reads of every row
    exp_rows[0] = D_C;
    exp_rows[1] = D_B;
    exp_rows[2] = D_V2;
    exp_rows[3] = D_V4;
    MReg = 3'd4;
    for (int i = 0; i < 4; i++) begin
      rd_rq   = 1'b1;
      rd_addr = AW'(i);
      step();
      chk($sformatf("b2b%0d_val", i), rd_val, 1'b1);
      chk($sformatf("b2b%0d_data", i), rd_data, exp_rows[i]);
    end
    rd_rq = 1'b0;
    step();
    chk("b2b_val_idle", rd_val, 1'b0);
    chk("b2b_err", err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
